signal_holder: RTL and testbench

//  - Retriggerable pulse stretcher. Any cycle with signal_in high drives signal_out high
//    for exactly HOLD_TIME clock cycles after that cycle.
//  - Used in the playfield renderer: one instance per collision direction (LEFT/RIGHT/DOWN/UP).
//    Per-pixel collision detects are one-cycle blips; the stretched flag stays stable for
//    the hero movement logic across a frame.

---
 rtl/signal_holder_pkg.sv | 16 +
 rtl/signal_holder.sv | 47 ++++
 tb/tb_signal_holder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/signal_holder_pkg.sv
// Game-wide constants shared by the playfield renderer and the collision pulse stretchers.
package signal_holder_pkg;

    // Sized for the 65 MHz pixel clock so a stretched collision flag spans a whole frame.
    localparam int COLLISION_HOLD_TIME = 1200000;

    localparam int NUM_DIRS = 4;

    typedef enum int unsigned {
        LEFT  = 0,
        RIGHT = 1,
        DOWN  = 2,
        UP    = 3
    } collision_dir_e;

endpackage

// File: rtl/signal_holder.sv
// Retriggerable pulse stretcher: a high input cycle holds signal_out high for HOLD_TIME cycles.
module signal_holder
    import signal_holder_pkg::*;
#(
    parameter int HOLD_TIME = COLLISION_HOLD_TIME,
    parameter bit RETRIGGER = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic signal_out
);

    localparam int CW = $clog2(longint'(HOLD_TIME) + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_TIME - 1);

    if (HOLD_TIME < 1) begin : g_bad_hold_time
        $fatal(1, "signal_holder: HOLD_TIME must be at least 1");
    end

    logic [CW-1:0] r_cnt;
    logic          r_out;
    logic          w_cnt_zero;
    logic          w_load;

    assign w_cnt_zero = (r_cnt == '0);
    // Without retrigger, input is still accepted on the cnt==0 cycle, extending the hold seamlessly.
    assign w_load     = signal_in && (RETRIGGER || w_cnt_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (w_load) begin
            r_cnt <= RELOAD;
            r_out <= 1'b1;
        end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
            r_out <= 1'b1;
        end else begin
            r_out <= 1'b0;
        end
    end

    assign signal_out = r_out;

endmodule

// File: tb/tb_signal_holder.sv
// Directed bench for signal_holder: retrigger, non-retrigger and HOLD_TIME=1 instances.
module tb_signal_holder;

    logic clk = 1'b0;
    logic rst;
    logic in_a, in_b, in_c;
    logic out_a, out_b, out_c;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    signal_holder #(.HOLD_TIME(4), .RETRIGGER(1'b1)) u_rt (
        .clk(clk), .rst(rst), .signal_in(in_a), .signal_out(out_a)
    );
    signal_holder #(.HOLD_TIME(4), .RETRIGGER(1'b0)) u_nr (
        .clk(clk), .rst(rst), .signal_in(in_b), .signal_out(out_b)
    );
    signal_holder #(.HOLD_TIME(1), .RETRIGGER(1'b1)) u_h1 (
        .clk(clk), .rst(rst), .signal_in(in_c), .signal_out(out_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce;
        rst  = 1'b1;
        in_a = 1'b0;
        in_b = 1'b0;
        in_c = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        in_a = 1'b1;
        in_b = 1'b1;
        in_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({out_a, out_b, out_c} !== 3'b000)
                $display("FAIL reset_hold cycle %0d: got %b%b%b expected 000", i, out_a, out_b, out_c);
            else passed++;
        end
        rst = 1'b0;
        tick();
        total++;
        if ({out_a, out_b, out_c} !== 3'b111)
            $display("FAIL reset_release: got %b%b%b expected 111", out_a, out_b, out_c);
        else passed++;
        quiesce();
    endtask

    task automatic test_single_pulse;
        logic [9:0] pin;
        logic [9:0] exp;
        pin = 10'b00_0000_0001;
        exp = 10'b00_0000_1111;
        for (int i = 0; i < 10; i++) begin
            in_a = pin[i];
            tick();
            total++;
            if (out_a !== exp[i])
                $display("FAIL single_pulse edge +%0d: got %b expected %b", i, out_a, exp[i]);
            else passed++;
        end
        quiesce();
    endtask

    task automatic test_retrigger;
        logic [9:0] pin;
        logic [9:0] exp;
        pin = 10'b00_0000_0101;
        exp = 10'b00_0011_1111;
        for (int i = 0; i < 10; i++) begin
            in_a = pin[i];
            tick();
            total++;
            if (out_a !== exp[i])
                $display("FAIL retrigger edge +%0d: got %b expected %b", i, out_a, exp[i]);
            else passed++;
        end
        quiesce();
    endtask

    task automatic test_no_retrigger;
        logic [9:0] pin [3];
        logic [9:0] exp [3];
        // pulses at +0/+2 and +0/+3 land while cnt!=0; pulse at +4 lands on cnt==0
        pin[0] = 10'b00_0000_0101;  exp[0] = 10'b00_0000_1111;
        pin[1] = 10'b00_0000_1001;  exp[1] = 10'b00_0000_1111;
        pin[2] = 10'b00_0001_0001;  exp[2] = 10'b00_1111_1111;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 10; i++) begin
                in_b = pin[v][i];
                tick();
                total++;
                if (out_b !== exp[v][i])
                    $display("FAIL no_retrigger vec %0d edge +%0d: got %b expected %b", v, i, out_b, exp[v][i]);
                else passed++;
            end
            quiesce();
        end
    endtask

    task automatic test_mid_hold_reset;
        logic [7:0] pin;
        logic [7:0] prst;
        logic [7:0] exp;
        pin  = 8'b0000_0001;
        prst = 8'b0000_0010;
        exp  = 8'b0000_0001;
        for (int i = 0; i < 8; i++) begin
            in_a = pin[i];
            in_b = pin[i];
            rst  = prst[i];
            tick();
            total++;
            if ({out_a, out_b} !== {exp[i], exp[i]})
                $display("FAIL mid_hold_reset edge +%0d: got %b%b expected %b%b", i, out_a, out_b, exp[i], exp[i]);
            else passed++;
        end
        quiesce();
    endtask

    task automatic test_hold_one;
        logic v;
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(1, 0));
            in_c = v;
            tick();
            total++;
            if (out_c !== v)
                $display("FAIL hold_one cycle %0d: got %b expected %b", i, out_c, v);
            else passed++;
        end
        quiesce();
    endtask

    task automatic test_continuous;
        int bad;
        bad = 0;
        in_a = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_a !== 1'b1) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL continuous_high: %0d low cycles seen, expected 0", bad);
        else passed++;
        in_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (out_a !== (i < 4))
                $display("FAIL continuous_release edge +%0d: got %b expected %b", i, out_a, (i < 4));
            else passed++;
        end
        quiesce();
    endtask

    initial begin
        rst  = 1'b1;
        in_a = 1'b0;
        in_b = 1'b0;
        in_c = 1'b0;
        tick();
        test_reset();
        test_single_pulse();
        test_retrigger();
        test_no_retrigger();
        test_mid_hold_reset();
        test_hold_one();
        test_continuous();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
